// File: rtl/fp_add_sched.sv
// fp_add_sched: shares one floating-point add/subtract unit among N requesters.
// A rotating-priority arbiter picks one requester per cycle, the winning operands
// are registered onto the unit, a {valid,id} shift register follows each op
// through the unit latency, and results land in a first-word fall-through FIFO
// that drives a single tagged response channel. A registered credit count
// (issue reg + tracker + FIFO) keeps the FIFO from ever overflowing.
module fp_add_sched #(
   parameter int N     = 4,
   parameter int LAT   = 2,
   parameter int DEPTH = 4,
   parameter int IDW   = $clog2(N)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N-1:0]        req_valid,
   output logic [N-1:0]        req_ready,
   input  logic [N-1:0]        req_op,
   input  logic [32*N-1:0]     req_a,
   input  logic [32*N-1:0]     req_b,
   output logic                fu_valid,
   output logic                fu_op,
   output logic [31:0]         fu_a,
   output logic [31:0]         fu_b,
   input  logic [31:0]         fu_c,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [IDW-1:0]      rsp_id,
   output logic [31:0]         rsp_c,
   output logic                busy
);

   localparam int DATA_W = 32;
   localparam int CW     = $clog2(DEPTH + 1);
   localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // arbitration and credit state
   logic [IDW-1:0]    ptr;
   logic [CW-1:0]     outstanding;
   logic [CW-1:0]     outstanding_next;
   logic              issue_ok;
   logic              gnt_found;
   logic [IDW-1:0]    gnt_idx;
   logic              hs;

   // issue register (stage p0)
   logic              vld_p0;
   logic [IDW-1:0]    id_p0;

   // tracker output / FIFO write side
   logic              push;
   logic [IDW-1:0]    push_id;

   // FIFO state
   logic              pop;
   logic              empty;
   logic              full;
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     fifo_cnt;
   logic [DATA_W-1:0] mem_c  [DEPTH];
   logic [IDW-1:0]    mem_id [DEPTH];

   // A credit is free only if the registered count is below DEPTH; a pop this
   // cycle is not visible here until the next cycle. Reset forces all grants off.
   assign issue_ok = !rst && (outstanding < CW'(DEPTH));

   // Rotating priority: first valid requester at or after ptr, wrapping around.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 0; k < N; k++) begin
         if (!gnt_found && req_valid[(int'(ptr) + k) % N]) begin
            gnt_found = 1'b1;
            gnt_idx   = IDW'((int'(ptr) + k) % N);
         end
      end
   end

   // One-hot ready toward the granted requester when a credit is available.
   always_comb begin
      req_ready = '0;
      if (issue_ok && gnt_found) begin
         req_ready[gnt_idx] = 1'b1;
      end
   end

   assign hs = issue_ok && gnt_found;

   // Advance the round-robin pointer past the requester that was just served.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (hs) begin
         ptr <= (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   // ---- stage p0: issue register driving the shared unit ----
   // Operands hold their last value when nothing is issued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p0 <= 1'b0;
         id_p0  <= '0;
         fu_op  <= 1'b0;
         fu_a   <= '0;
         fu_b   <= '0;
      end else begin
         vld_p0 <= hs;
         if (hs) begin
            id_p0 <= gnt_idx;
            fu_op <= req_op[gnt_idx];
            fu_a  <= req_a[int'(gnt_idx) * DATA_W +: DATA_W];
            fu_b  <= req_b[int'(gnt_idx) * DATA_W +: DATA_W];
         end
      end
   end

   assign fu_valid = vld_p0;

   // ---- stages p1..pLAT: in-flight tracker matching the unit latency ----
   generate
      if (LAT == 0) begin : g_trk_none
         assign push    = vld_p0;
         assign push_id = id_p0;
      end else begin : g_trk
         logic           vld_p1 [LAT];
         logic [IDW-1:0] id_p1  [LAT];

         // Shift {valid,id} along with the op so fu_c is captured on the right cycle.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int s = 0; s < LAT; s++) begin
                  vld_p1[s] <= 1'b0;
                  id_p1[s]  <= '0;
               end
            end else begin
               vld_p1[0] <= vld_p0;
               id_p1[0]  <= id_p0;
               for (int s = 1; s < LAT; s++) begin
                  vld_p1[s] <= vld_p1[s-1];
                  id_p1[s]  <= id_p1[s-1];
               end
            end
         end

         assign push    = vld_p1[LAT-1];
         assign push_id = id_p1[LAT-1];
      end
   endgenerate

   // ---- result FIFO (first-word fall-through) ----
   assign empty = (fifo_cnt == '0);
   assign full  = (fifo_cnt == CW'(DEPTH));
   assign pop   = !empty && rsp_ready;

   // FIFO pointers and occupancy; push and pop together leave the count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            fifo_cnt <= fifo_cnt + 1'b1;
         end else if (!push && pop) begin
            fifo_cnt <= fifo_cnt - 1'b1;
         end
      end
   end

   // Result storage; contents are only observed through the occupancy above.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_c[wr_ptr]  <= fu_c;
         mem_id[wr_ptr] <= push_id;
      end
   end

   // Head entry is presented directly; outputs read zero while the FIFO is empty.
   assign rsp_valid = !empty;
   assign rsp_c     = empty ? '0 : mem_c[rd_ptr];
   assign rsp_id    = empty ? '0 : mem_id[rd_ptr];

   // ---- credit accounting ----
   // Ops enter on a handshake and leave on a pop; internal moves do not change the total.
   always_comb begin
      outstanding_next = outstanding;
      if (hs && !pop) begin
         outstanding_next = outstanding + 1'b1;
      end else if (!hs && pop) begin
         outstanding_next = outstanding - 1'b1;
      end
   end

   // Registered credit count and busy flag, both tracking the same total.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outstanding <= '0;
         busy        <= 1'b0;
      end else begin
         outstanding <= outstanding_next;
         busy        <= (outstanding_next != '0);
      end
   end

   // Credits guarantee a free slot for every push unless a pop frees one the same cycle.
   overflow_chk : assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: tb/tb_fp_add_sched.sv
// Testbench for fp_add_sched: table-driven single-op vectors plus hand-written
// sequences for arbitration order, pointer wrap, backpressure and mid-flight reset.
module tb_fp_add_sched;
   localparam int N     = 4;
   localparam int LAT   = 2;
   localparam int DEPTH = 4;
   localparam int IDW   = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N-1:0]      req_op;
   logic [32*N-1:0]   req_a;
   logic [32*N-1:0]   req_b;
   logic              fu_valid;
   logic              fu_op;
   logic [31:0]       fu_a;
   logic [31:0]       fu_b;
   logic [31:0]       fu_c;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [31:0]       rsp_c;
   logic              busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fp_add_sched #(.N(N), .LAT(LAT), .DEPTH(DEPTH), .IDW(IDW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b),
      .fu_valid(fu_valid), .fu_op(fu_op), .fu_a(fu_a), .fu_b(fu_b), .fu_c(fu_c),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_c(rsp_c),
      .busy(busy)
   );

   // Stand-in for the shared FP unit: exact IEEE results for the operand pairs
   // used below, a fixed scramble for anything else.
   function automatic logic [31:0] fu_model(input logic op, input logic [31:0] a, input logic [31:0] b);
      case ({op, a, b})
         {1'b0, 32'h3F800000, 32'h40000000}: return 32'h40400000;
         {1'b1, 32'h40400000, 32'h3F800000}: return 32'h40000000;
         {1'b0, 32'h40000000, 32'h40000000}: return 32'h40800000;
         {1'b1, 32'h3F800000, 32'h3F800000}: return 32'h00000000;
         {1'b0, 32'hBF800000, 32'h3F800000}: return 32'h00000000;
         {1'b0, 32'h40400000, 32'h40400000}: return 32'h40C00000;
         {1'b1, 32'h40A00000, 32'h3F800000}: return 32'h40800000;
         default: return a ^ {b[15:0], b[31:16]} ^ {31'b0, op};
      endcase
   endfunction

   // Unit model with LAT cycles of latency from fu_valid.
   logic [31:0] fu_pipe [LAT];
   always @(posedge clk) begin
      fu_pipe[0] <= fu_model(fu_op, fu_a, fu_b);
      for (int i = 1; i < LAT; i++) fu_pipe[i] <= fu_pipe[i-1];
   end
   assign fu_c = fu_pipe[LAT-1];

   typedef struct {
      logic [N-1:0] vmask;
      int           id;
      logic         op;
      logic [31:0]  a;
      logic [31:0]  b;
      logic [31:0]  c;
   } vec_t;

   typedef struct {
      logic [IDW-1:0] id;
      logic [31:0]    c;
   } exp_t;

   exp_t          expq[$];
   logic          prev_hs;
   logic [N-1:0]  last_rdy;
   int            last_gnt;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_req(input int i, input logic op, input logic [31:0] a, input logic [31:0] b);
      req_op[i]          = op;
      req_a[i*32 +: 32]  = a;
      req_b[i*32 +: 32]  = b;
   endtask

   // One op in isolation: grant, issue at T+1, response at T+4, idle at T+5.
   task automatic run_single(input vec_t v, input string tag);
      set_req(v.id, v.op, v.a, v.b);
      req_valid = v.vmask;
      rsp_ready = 1'b1;
      #1;
      chk({tag, " ready"}, 32'(req_ready), 32'(1) << v.id);
      @(negedge clk);
      req_valid = '0;
      chk({tag, " fu_valid"}, 32'(fu_valid), 32'd1);
      chk({tag, " fu_op"}, 32'(fu_op), 32'(v.op));
      chk({tag, " fu_a"}, fu_a, v.a);
      chk({tag, " fu_b"}, fu_b, v.b);
      chk({tag, " busy"}, 32'(busy), 32'd1);
      @(negedge clk);
      chk({tag, " fu_valid_off"}, 32'(fu_valid), 32'd0);
      chk({tag, " fu_a_hold"}, fu_a, v.a);
      chk({tag, " rsp_early2"}, 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk({tag, " rsp_early3"}, 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, " rsp_id"}, 32'(rsp_id), 32'(v.id));
      chk({tag, " rsp_c"}, rsp_c, v.c);
      @(negedge clk);
      chk({tag, " rsp_gone"}, 32'(rsp_valid), 32'd0);
      chk({tag, " busy_low"}, 32'(busy), 32'd0);
   endtask

   // One cycle with the scoreboard: record handshakes, compare pops, check issue follows grant.
   task automatic step();
      logic [N-1:0] h;
      exp_t         e;
      #1;
      h = req_valid & req_ready;
      chk("fu_valid_follows_hs", 32'(fu_valid), 32'(prev_hs));
      last_rdy = req_ready;
      last_gnt = -1;
      for (int i = 0; i < N; i++) begin
         if (h[i]) begin
            last_gnt = i;
            e.id = IDW'(i);
            e.c  = fu_model(req_op[i], req_a[i*32 +: 32], req_b[i*32 +: 32]);
            expq.push_back(e);
         end
      end
      if (rsp_valid && rsp_ready) begin
         if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected actual_id=%0d actual_c=%h expected=none", rsp_id, rsp_c);
         end else begin
            e = expq.pop_front();
            chk("sb_rsp_id", 32'(rsp_id), 32'(e.id));
            chk("sb_rsp_c", rsp_c, e.c);
         end
      end
      prev_hs = |h;
      @(negedge clk);
   endtask

   vec_t        vecs[5];
   vec_t        v;
   int          grants[$];
   int          per_req[N];
   int          nhs;
   logic [31:0] held_c;
   logic [IDW-1:0] held_id;

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{vmask: 4'b0100, id: 2, op: 1'b0, a: 32'h3F800000, b: 32'h40000000, c: 32'h40400000};
      vecs[1] = '{vmask: 4'b0001, id: 0, op: 1'b1, a: 32'h40400000, b: 32'h3F800000, c: 32'h40000000};
      vecs[2] = '{vmask: 4'b0100, id: 2, op: 1'b0, a: 32'h40000000, b: 32'h40000000, c: 32'h40800000};
      vecs[3] = '{vmask: 4'b0010, id: 1, op: 1'b1, a: 32'h3F800000, b: 32'h3F800000, c: 32'h00000000};
      vecs[4] = '{vmask: 4'b1000, id: 3, op: 1'b0, a: 32'hBF800000, b: 32'h3F800000, c: 32'h00000000};

      rst = 1'b1;
      req_valid = '1;
      req_op = '0;
      req_a = '0;
      req_b = '0;
      rsp_ready = 1'b1;
      prev_hs = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("reset ready", 32'(req_ready), 32'd0);
      chk("reset fu_valid", 32'(fu_valid), 32'd0);
      chk("reset fu_a", fu_a, 32'd0);
      chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset rsp_c", rsp_c, 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      req_valid = '0;
      rst = 1'b0;
      @(negedge clk);

      // Table of isolated ops
      for (int k = 0; k < 5; k++) run_single(vecs[k], $sformatf("vec%0d", k));

      // Pointer wrap with sparse requests (ptr is 0 here)
      prev_hs = 1'b0;
      set_req(1, 1'b1, 32'h40A00000, 32'h3F800000);
      set_req(2, 1'b0, 32'h40400000, 32'h40400000);
      req_valid = 4'b0100;
      step();
      chk("wrap grant2", 32'(last_gnt), 32'd2);
      req_valid = 4'b0010;
      step();
      chk("wrap grant1", 32'(last_gnt), 32'd1);
      req_valid = 4'b0110;
      step();
      chk("wrap ptr2", 32'(last_gnt), 32'd2);
      req_valid = '0;
      for (int k = 0; k < 8; k++) step();
      chk("wrap drained", 32'(expq.size()), 32'd0);

      // Fairness: all requesters valid from a fresh pointer
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      prev_hs = 1'b0;
      expq.delete();
      set_req(0, 1'b0, 32'h3F800000, 32'h40000000);
      set_req(1, 1'b1, 32'h40400000, 32'h3F800000);
      set_req(2, 1'b0, 32'h40000000, 32'h40000000);
      set_req(3, 1'b1, 32'h40A00000, 32'h3F800000);
      req_valid = '1;
      for (int k = 0; k < N; k++) per_req[k] = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (last_gnt >= 0) begin
            grants.push_back(last_gnt);
            per_req[last_gnt]++;
         end
      end
      for (int k = 0; k < grants.size(); k++)
         chk($sformatf("rr order %0d", k), 32'(grants[k]), 32'(k % N));
      for (int k = 0; k < N; k++)
         chk($sformatf("rr served %0d", k), 32'(per_req[k] >= 2), 32'd1);
      req_valid = '0;
      for (int k = 0; k < 8; k++) step();
      chk("rr drained", 32'(expq.size()), 32'd0);

      // Backpressure: FIFO fills, issue stops at DEPTH credits
      rsp_ready = 1'b0;
      set_req(1, 1'b0, 32'h00001000, 32'h00000002);
      req_valid = 4'b0010;
      nhs = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (last_gnt == 1) begin
            nhs++;
            req_a[32 +: 32] = req_a[32 +: 32] + 32'd1;
         end
         if (k == 5) begin
            held_c  = rsp_c;
            held_id = rsp_id;
         end
      end
      chk("bp handshakes", 32'(nhs), 32'd4);
      chk("bp ready_low", 32'(last_rdy), 32'd0);
      chk("bp rsp_c_stable", rsp_c, held_c);
      chk("bp rsp_id_stable", 32'(rsp_id), 32'(held_id));
      chk("bp busy", 32'(busy), 32'd1);
      rsp_ready = 1'b1;
      step();
      chk("bp no_reuse_same_cycle", 32'(last_rdy), 32'd0);
      step();
      chk("bp resume", 32'(last_rdy), 32'b0010);
      req_valid = '0;
      for (int k = 0; k < 10; k++) step();
      chk("bp drained", 32'(expq.size()), 32'd0);

      // Reset with three ops in flight and one buffered
      rsp_ready = 1'b0;
      req_valid = '1;
      for (int k = 0; k < 4; k++) step();
      chk("rst pre buffered", 32'(rsp_valid), 32'd1);
      chk("rst pre inflight", 32'(fu_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst async ready", 32'(req_ready), 32'd0);
      chk("rst async fu_valid", 32'(fu_valid), 32'd0);
      chk("rst async rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst async rsp_c", rsp_c, 32'd0);
      chk("rst async busy", 32'(busy), 32'd0);
      expq.delete();
      @(negedge clk);
      rst = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk($sformatf("rst no_stale %0d", k), 32'(rsp_valid), 32'd0);
      end
      v = '{vmask: 4'b1111, id: 0, op: 1'b0, a: 32'h40400000, b: 32'h40400000, c: 32'h40C00000};
      run_single(v, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fp_add_sched.md
Name: fp_add_sched

Overview:
- Shares one floating-point add/subtract unit among N requesters.
- Round-robin arbitration over per-requester valid/ready channels.
- Registers the winning operands onto the unit and tracks in-flight operations through the unit's fixed latency.
- Buffers results in a credit-protected FIFO and returns them on a single tagged response channel with backpressure.

Parameters:
- N, 4: number of requesters (2..8).
- LAT, 2: cycles from fu_valid to matching fu_c (0 = combinational unit).
- DEPTH, 4: result FIFO depth and max outstanding ops; needs DEPTH >= LAT+2 for full throughput.
- IDW, $clog2(N): requester id width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  N  request valid per requester
- req_ready  out  N  request accepted (combinational)
- req_op  in  N  0 = add, 1 = subtract, per requester
- req_a  in  32*N  operand a, requester i at [32i+31:32i]
- req_b  in  32*N  operand b, same packing
- fu_valid  out  1  operands on fu_* valid this cycle
- fu_op  out  1  op to shared unit
- fu_a  out  32  operand a to shared unit
- fu_b  out  32  operand b to shared unit
- fu_c  in  32  unit result, LAT cycles after fu_valid
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IDW  requester that issued this result
- rsp_c  out  32  IEEE-754 single result
- busy  out  1  any op in issue reg, pipe tracker or FIFO

Behaviour:
Reset (async, immediate):
- All outputs 0; rr pointer 0; FIFO empty; tracker cleared; credit count 0.
- Asserting rst mid-operation discards all in-flight and buffered results; no response is produced for them.

Credits:
- outstanding = ops in issue reg + tracker + FIFO entries, registered.
- Issue allowed only when outstanding < DEPTH.
- A pop in cycle T frees its credit from T+1; no same-cycle credit reuse.

Arbitration:
- When issue is allowed, grant the lowest index i >= ptr with req_valid[i]; otherwise wrap to the lowest i < ptr.
- req_ready[grant] = 1, all other bits 0. If issue is not allowed, all bits 0.
- req_ready depends on req_valid, but req_valid must not depend on req_ready.
- On handshake to requester i: ptr <= (i+1) mod N. With no handshake, ptr holds.
- At most one handshake per cycle.

Issue stage:
- Handshake in cycle T latches op, a, b, id.
- In T+1: fu_valid = 1 with those values on fu_op, fu_a, fu_b.
- If there is no handshake in T: fu_valid = 0 in T+1, and fu_a/fu_b/fu_op hold their previous values.
- Back-to-back issue every cycle is allowed.

Tracker:
- LAT-stage shift register of {valid, id} fed from the issue register.
- In the cycle the LAT-th stage is valid (T+1+LAT), fu_c is sampled and pushed into the FIFO together with its id.
- LAT = 0: fu_c is sampled in T+1.

FIFO and response:
- Synchronous FIFO, DEPTH entries, first-word fall-through.
- rsp_valid = !empty; rsp_c and rsp_id show the head entry.
- Pop on rsp_valid & rsp_ready.
- Simultaneous push and pop is legal, including when full or empty; count is unchanged.
- Overflow cannot occur because of credits; an overflow attempt is an assertion failure.
- Pointers wrap modulo DEPTH.
- Earliest response: handshake at T gives rsp_valid at T+2+LAT.
- Results return in issue order; no reordering.

Stability:
- While rsp_valid & !rsp_ready, rsp_c and rsp_id are held stable.

busy:
- busy = (outstanding != 0), registered.

Test Plan:
- Single op (N=4, LAT=2, DEPTH=4): req 2, a=0x3F800000, b=0x40000000, op=0, at cycle T. Required: fu_valid at T+1 with those operands; fu model returns 0x40400000; rsp_valid at T+4 with rsp_id=2, rsp_c=0x40400000; busy low at T+5 when rsp_ready=1.
- Subtract: req 0, op=1, a=0x40400000, b=0x3F800000. Required: fu_op=1; rsp_c=0x40000000, rsp_id=0.
- Fairness: all four req_valid held high, rsp_ready=1, 12 cycles. Required: grants 0,1,2,3,0,1,...; one fu_valid per cycle; rsp_id sequence identical; no requester starved.
- Backpressure: rsp_ready=0, req 1 continuously valid. Required: exactly 4 handshakes, then req_ready=0; FIFO holds 4 in order with rsp_c stable. Set rsp_ready=1. Required: pops at 1/cycle; issue resumes the cycle after the first pop.
- Pointer wrap and sparse requests: ptr=3 after a grant to 2; only req 1 valid. Required: grant 1, ptr becomes 2.
- Reset mid-flight: assert rst with 3 ops in flight and 1 buffered. Required: outputs 0 asynchronously; after deassertion no stale rsp_valid; ptr=0; a new op completes with normal latency.
